fetch_prefix_unit: RTL and testbench



---
 rtl/fetch_prefix_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_prefix_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefix_unit.sv
// ============================================================================
// Module   : fetch_prefix_unit
// Purpose  : Instruction fetch with PRE-word absorption, feeding the immediate
//            generator and issuing instructions to execute via valid/accept.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_prefix_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  OP_PRE   = 4'hE,
    parameter logic [3:0]  OP_LUI   = 4'hD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        memRead,
    output logic [15:0] memAddr,
    input  logic        memReady,
    input  logic [15:0] memData,
    input  logic        loadPC,
    input  logic [15:0] newPC,
    output logic        instValid,
    input  logic        instAccept,
    output logic [15:0] IR,
    output logic [11:0] inIR,
    output logic [3:0]  inOF,
    output logic        conOF,
    output logic        selLOP,
    output logic        SE12bits,
    output logic        SE4bits
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [15:0] c_HALT = 16'hC000;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  of_q, of_d;
    logic        ofpend_q, ofpend_d;

    logic [3:0]  w_opc;
    logic [3:0]  w_mem_opc;
    logic        w_issue;
    logic        w_imm_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            of_q     <= 4'h0;
            ofpend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            of_q     <= of_d;
            ofpend_q <= ofpend_d;
        end
    end

    assign w_mem_opc = memData[15:12];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        of_d     = of_q;
        ofpend_d = ofpend_q;
        case (state_q)
            S_IDLE: begin
                // A redirect while idle only moves the PC; it does not start fetching.
                if (loadPC) begin
                    pc_d = newPC;
                end else if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (loadPC) begin
                    pc_d     = newPC;
                    ofpend_d = 1'b0;
                end else if (memReady) begin
                    ir_d = memData;
                    pc_d = pc_q + 16'd1;
                    if (w_mem_opc == OP_PRE) begin
                        of_d     = memData[3:0];
                        ofpend_d = 1'b1;
                    end else if (w_mem_opc == OP_LUI) begin
                        of_d    = memData[3:0];
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (loadPC) begin
                    pc_d     = newPC;
                    ofpend_d = 1'b0;
                    state_d  = S_FETCH;
                end else if (instAccept) begin
                    ofpend_d = 1'b0;
                    state_d  = (ir_q == c_HALT) ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_issue    = (state_q == S_ISSUE);
    assign w_opc      = ir_q[15:12];
    assign w_imm_type = (w_opc <= 4'hB);

    assign memRead   = (state_q == S_FETCH);
    assign memAddr   = pc_q;
    assign instValid = w_issue;
    assign IR        = ir_q;
    assign inIR      = ir_q[11:0];
    assign inOF      = of_q;

    // Decode flags are qualified by ISSUE so the immediate generator sees
    // nothing while a PRE word or a stale IR sits in the register.
    assign conOF    = w_issue & ofpend_q & w_imm_type;
    assign selLOP   = w_issue & (w_opc == OP_LUI);
    assign SE12bits = w_issue & (w_opc <= 4'h7);
    assign SE4bits  = w_issue & (w_opc >= 4'h8) & (w_opc <= 4'hB);

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefix_unit.sv
// ============================================================================
// Module   : tb_fetch_prefix_unit
// Purpose  : Directed, table-driven self-checking bench for fetch_prefix_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_prefix_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        memRead;
    logic [15:0] memAddr;
    logic        memReady;
    logic [15:0] memData;
    logic        loadPC;
    logic [15:0] newPC;
    logic        instValid;
    logic        instAccept;
    logic [15:0] IR;
    logic [11:0] inIR;
    logic [3:0]  inOF;
    logic        conOF;
    logic        selLOP;
    logic        SE12bits;
    logic        SE4bits;

    fetch_prefix_unit #(
        .RESET_PC (16'h0000),
        .OP_PRE   (4'hE),
        .OP_LUI   (4'hD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .memRead    (memRead),
        .memAddr    (memAddr),
        .memReady   (memReady),
        .memData    (memData),
        .loadPC     (loadPC),
        .newPC      (newPC),
        .instValid  (instValid),
        .instAccept (instAccept),
        .IR         (IR),
        .inIR       (inIR),
        .inOF       (inOF),
        .conOF      (conOF),
        .selLOP     (selLOP),
        .SE12bits   (SE12bits),
        .SE4bits    (SE4bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        use_pre;
        logic [15:0] pre_w;
        logic [15:0] w;
        logic        con;
        logic        lop;
        logic        se12;
        logic        se4;
        logic [3:0]  of;
    } vec_t;

    vec_t        vecs [10];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (memRead !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_req", {31'd0, memRead}, 32'd1);
    endtask

    task automatic fetch(input logic [15:0] w);
        wait_fetch();
        chk("fetch_addr", {16'd0, memAddr}, {16'd0, exp_pc});
        memData  = w;
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        exp_pc   = exp_pc + 16'd1;
    endtask

    task automatic accept();
        instAccept = 1'b1;
        @(negedge clk);
        instAccept = 1'b0;
    endtask

    task automatic check_issue(input logic [15:0] w, input logic con, input logic lop,
                               input logic se12, input logic se4, input logic [3:0] of);
        chk("instValid", {31'd0, instValid}, 32'd1);
        chk("IR",        {16'd0, IR},        {16'd0, w});
        chk("inIR",      {20'd0, inIR},      {20'd0, w[11:0]});
        chk("conOF",     {31'd0, conOF},     {31'd0, con});
        chk("selLOP",    {31'd0, selLOP},    {31'd0, lop});
        chk("SE12bits",  {31'd0, SE12bits},  {31'd0, se12});
        chk("SE4bits",   {31'd0, SE4bits},   {31'd0, se4});
        chk("inOF",      {28'd0, inOF},      {28'd0, of});
        chk("issue_memRead", {31'd0, memRead}, 32'd0);
        chk("issue_pc",  {16'd0, memAddr},   {16'd0, exp_pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            pre   pre_w     word      con   lop   se12  se4   of
        vecs[0] = '{1'b0, 16'h0000, 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 16'hE00A, 16'h8123, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA};
        vecs[2] = '{1'b0, 16'h0000, 16'h8123, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA};
        vecs[3] = '{1'b0, 16'h0000, 16'hD007, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7};
        vecs[4] = '{1'b1, 16'hE003, 16'h2FFF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3};
        vecs[5] = '{1'b1, 16'hE009, 16'hC123, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9};
        vecs[6] = '{1'b0, 16'h0000, 16'h7000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9};
        vecs[7] = '{1'b1, 16'hE004, 16'hD0A0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[8] = '{1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
        vecs[9] = '{1'b0, 16'h0000, 16'hB5A5, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};

        rst = 1'b1; start = 1'b0; memReady = 1'b0; memData = 16'h0000;
        loadPC = 1'b0; newPC = 16'h0000; instAccept = 1'b0;
        exp_pc = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_memRead",   {31'd0, memRead},   32'd0);
        chk("rst_memAddr",   {16'd0, memAddr},   32'h0000);
        chk("rst_instValid", {31'd0, instValid}, 32'd0);
        chk("rst_IR",        {16'd0, IR},        32'h0000);
        chk("rst_flags",     {28'd0, conOF, selLOP, SE12bits, SE4bits}, 32'd0);
        chk("rst_inOF",      {28'd0, inOF},      32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_fetch", {31'd0, memRead}, 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].use_pre) begin
                fetch(vecs[i].pre_w);
                chk("pre_not_issued", {31'd0, instValid}, 32'd0);
                chk("pre_keeps_read", {31'd0, memRead},   32'd1);
            end
            fetch(vecs[i].w);
            check_issue(vecs[i].w, vecs[i].con, vecs[i].lop, vecs[i].se12,
                        vecs[i].se4, vecs[i].of);
            accept();
            chk("post_accept_read", {31'd0, memRead}, 32'd1);
            chk("post_accept_addr", {16'd0, memAddr}, {16'd0, exp_pc});
            chk("fetch_flags_off",  {28'd0, conOF, selLOP, SE12bits, SE4bits}, 32'd0);
        end

        // Back-to-back prefixes: the last one supplies the offset.
        fetch(16'hE001);
        fetch(16'hE00F);
        chk("dbl_pre_no_issue", {31'd0, instValid}, 32'd0);
        fetch(16'hB010);
        check_issue(16'hB010, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
        accept();

        // Execute stalls: everything held, no fetch.
        fetch(16'h9ABC);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_issue(16'h9ABC, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
        end
        accept();

        // Redirect colliding with memReady while a prefix is pending.
        fetch(16'hE00C);
        memData  = 16'h1111;
        memReady = 1'b1;
        loadPC   = 1'b1;
        newPC    = 16'h0040;
        @(negedge clk);
        memReady = 1'b0;
        loadPC   = 1'b0;
        exp_pc   = 16'h0040;
        chk("redir_IR",      {16'd0, IR},        32'h0000E00C);
        chk("redir_addr",    {16'd0, memAddr},   32'h00000040);
        chk("redir_read",    {31'd0, memRead},   32'd1);
        chk("redir_novalid", {31'd0, instValid}, 32'd0);
        fetch(16'h8000);
        check_issue(16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
        accept();

        // Redirect in the accept cycle.
        fetch(16'h0123);
        instAccept = 1'b1;
        loadPC     = 1'b1;
        newPC      = 16'h0100;
        @(negedge clk);
        instAccept = 1'b0;
        loadPC     = 1'b0;
        exp_pc     = 16'h0100;
        chk("redir_iss_read", {31'd0, memRead}, 32'd1);
        chk("redir_iss_addr", {16'd0, memAddr}, 32'h00000100);
        chk("redir_iss_IR",   {16'd0, IR},      32'h00000123);

        // HALT returns to IDLE.
        fetch(16'hC000);
        check_issue(16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC);
        accept();
        chk("halt_read",  {31'd0, memRead},   32'd0);
        chk("halt_valid", {31'd0, instValid}, 32'd0);
        @(negedge clk);
        chk("halt_stays_idle", {31'd0, memRead}, 32'd0);

        // Redirect in IDLE, then PC wrap.
        loadPC = 1'b1;
        newPC  = 16'hFFFF;
        @(negedge clk);
        loadPC = 1'b0;
        exp_pc = 16'hFFFF;
        chk("idle_redir_read", {31'd0, memRead}, 32'd0);
        chk("idle_redir_addr", {16'd0, memAddr}, 32'h0000FFFF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fetch(16'h3000);
        chk("wrap_addr", {16'd0, memAddr}, 32'h00000000);
        check_issue(16'h3000, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC);
        accept();

        // Asynchronous reset mid-fetch.
        chk("pre_rst_read", {31'd0, memRead}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_read", {31'd0, memRead}, 32'd0);
        chk("async_rst_addr", {16'd0, memAddr}, 32'h0000);
        chk("async_rst_IR",   {16'd0, IR},      32'h0000);
        chk("async_rst_inOF", {28'd0, inOF},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_idle", {31'd0, memRead}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
